glitch_filter: RTL and testbench

//  - Downstream consumer of the combinational gate-delay stage's output y (din here).
//  - Unequal gate delays upstream produce hazard pulses on y; this block synchronises
//    din into clk, rejects pulses shorter than STABLE_CYCLES samples and emits a

---
 rtl/glitch_filter_pkg.sv | 15 +
 rtl/sync_2ff.sv | 30 +++
 rtl/glitch_filter.sv | 167 ++++++++++++++++
 tb/tb_glitch_filter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/glitch_filter_pkg.sv
// Shared FSM encoding and default parameters for the glitch filter.
// The GLITCH_COUNT_EN build option is consumed by glitch_filter.sv.
package glitch_filter_pkg;

    localparam int DEF_STABLE_CYCLES = 4;
    localparam int DEF_CNT_W         = 8;

    typedef enum logic [1:0] {
        LOW      = 2'b00,
        RISE_CHK = 2'b01,
        HIGH     = 2'b11,
        FALL_CHK = 2'b10
    } gf_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// Both stages clear to 0 on asynchronous active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic q1_q, q1_d;
    logic q2_q, q2_d;

    always_comb begin
        q1_d = d;
        q2_d = q1_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q1_q <= 1'b0;
            q2_q <= 1'b0;
        end else begin
            q1_q <= q1_d;
            q2_q <= q2_d;
        end
    end

    assign q = q2_q;

endmodule

// File: rtl/glitch_filter.sv
// Synchronises din, accepts a new level only after STABLE_CYCLES equal samples,
// emits rise/fall strobes and counts edges. Define GLITCH_COUNT_EN to count rejected pulses.
module glitch_filter
    import glitch_filter_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             din,
    input  logic             clr,
    output logic             dout,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] edge_cnt,
    output logic [CNT_W-1:0] glitch_cnt
);

    localparam int SC_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(STABLE_CYCLES - 1);

    logic s;

    gf_state_e        state_q, state_d;
    logic [SC_W-1:0]  stab_cnt_q, stab_cnt_d;
    logic             dout_q, dout_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;

    sync_2ff u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (din),
        .q       (s)
    );

    always_comb begin
        state_d    = state_q;
        stab_cnt_d = stab_cnt_q;
        dout_d     = dout_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        case (state_q)
            LOW: begin
                if (s) begin
                    // A single required sample means the first opposite sample is decisive.
                    if (STABLE_CYCLES == 1) begin
                        state_d    = HIGH;
                        dout_d     = 1'b1;
                        rise_d     = 1'b1;
                        stab_cnt_d = '0;
                    end else begin
                        state_d    = RISE_CHK;
                        stab_cnt_d = SC_W'(1);
                    end
                end
            end
            RISE_CHK: begin
                if (s) begin
                    if (stab_cnt_q == SC_LAST) begin
                        state_d    = HIGH;
                        dout_d     = 1'b1;
                        rise_d     = 1'b1;
                        stab_cnt_d = '0;
                    end else begin
                        stab_cnt_d = stab_cnt_q + SC_W'(1);
                    end
                end else begin
                    state_d    = LOW;
                    stab_cnt_d = '0;
                end
            end
            HIGH: begin
                if (!s) begin
                    if (STABLE_CYCLES == 1) begin
                        state_d    = LOW;
                        dout_d     = 1'b0;
                        fall_d     = 1'b1;
                        stab_cnt_d = '0;
                    end else begin
                        state_d    = FALL_CHK;
                        stab_cnt_d = SC_W'(1);
                    end
                end
            end
            FALL_CHK: begin
                if (!s) begin
                    if (stab_cnt_q == SC_LAST) begin
                        state_d    = LOW;
                        dout_d     = 1'b0;
                        fall_d     = 1'b1;
                        stab_cnt_d = '0;
                    end else begin
                        stab_cnt_d = stab_cnt_q + SC_W'(1);
                    end
                end else begin
                    state_d    = HIGH;
                    stab_cnt_d = '0;
                end
            end
            default: begin
                state_d    = LOW;
                stab_cnt_d = '0;
            end
        endcase
    end

    // Clear first, then count, so a clear coinciding with an edge leaves 1.
    always_comb begin
        edge_cnt_d = clr ? '0 : edge_cnt_q;
        if (rise_d) begin
            edge_cnt_d = edge_cnt_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= LOW;
            stab_cnt_q <= '0;
            dout_q     <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            edge_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            stab_cnt_q <= stab_cnt_d;
            dout_q     <= dout_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end

`ifdef GLITCH_COUNT_EN
    logic             abort;
    logic [CNT_W-1:0] glitch_cnt_q, glitch_cnt_d;

    assign abort = ((state_q == RISE_CHK) && !s) || ((state_q == FALL_CHK) && s);

    always_comb begin
        glitch_cnt_d = clr ? '0 : glitch_cnt_q;
        if (abort) begin
            glitch_cnt_d = glitch_cnt_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            glitch_cnt_q <= '0;
        end else begin
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign glitch_cnt = glitch_cnt_q;
`else
    assign glitch_cnt = '0;
`endif

    assign dout     = dout_q;
    assign rise     = rise_q;
    assign fall     = fall_q;
    assign edge_cnt = edge_cnt_q;

endmodule

// File: tb/tb_glitch_filter.sv
// Directed self-checking bench: default-parameter DUT plus a STABLE_CYCLES=1 DUT.
module tb_glitch_filter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       din, din1, clr;
    logic       dout, rise, fall;
    logic [7:0] edge_cnt, glitch_cnt;
    logic       dout1, rise1, fall1;
    logic [7:0] edge_cnt1, glitch_cnt1;

    int n_tests = 0;
    int n_fail  = 0;
    int rise_seen = 0;
    int fall_seen = 0;
    int dout_changes = 0;
    logic dout_prev = 1'b0;
    int g_inc;
    int g_exp = 0;
    int base_rise, base_chg;

    always #5 clk = ~clk;

    glitch_filter u_dut (
        .clk(clk), .reset_n(reset_n), .din(din), .clr(clr),
        .dout(dout), .rise(rise), .fall(fall),
        .edge_cnt(edge_cnt), .glitch_cnt(glitch_cnt)
    );

    glitch_filter #(.STABLE_CYCLES(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .din(din1), .clr(clr),
        .dout(dout1), .rise(rise1), .fall(fall1),
        .edge_cnt(edge_cnt1), .glitch_cnt(glitch_cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rise === 1'b1) rise_seen++;
        if (fall === 1'b1) fall_seen++;
        if (dout !== dout_prev) dout_changes++;
        dout_prev = dout;
    endtask

    task automatic qual_rise();
        din = 1'b1;
        repeat (7) tick();
        din = 1'b0;
        repeat (7) tick();
    endtask

    initial begin
`ifdef GLITCH_COUNT_EN
        g_inc = 1;
`else
        g_inc = 0;
`endif
        reset_n = 1'b0; din = 1'b0; din1 = 1'b0; clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_dout", dout, 0);
        chk("reset_rise", rise, 0);
        chk("reset_fall", fall, 0);
        chk("reset_edge_cnt", edge_cnt, 0);
        chk("reset_glitch_cnt", glitch_cnt, 0);
        reset_n = 1'b1;
        repeat (2) tick();

        // 1: accepted rise appears on the 6th edge counting the capture edge
        din = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("t1_early_dout_%0d", i), {dout, rise}, 0);
        end
        tick();
        chk("t1_dout", dout, 1);
        chk("t1_rise", rise, 1);
        chk("t1_edge_cnt", edge_cnt, 1);
        tick();
        chk("t1_rise_one_cycle", rise, 0);
        din = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("t1_fall_early_%0d", i), {dout, fall}, 2);
        end
        tick();
        chk("t1_fall_dout", dout, 0);
        chk("t1_fall", fall, 1);
        tick();
        chk("t1_fall_one_cycle", fall, 0);

        // 2: two-cycle pulse is rejected
        base_rise = rise_seen; base_chg = dout_changes;
        din = 1'b1;
        repeat (2) tick();
        din = 1'b0;
        repeat (10) tick();
        g_exp += g_inc;
        chk("t2_no_rise", rise_seen - base_rise, 0);
        chk("t2_no_dout_change", dout_changes - base_chg, 0);
        chk("t2_glitch_cnt", glitch_cnt, g_exp);

        // 3: short hazard pulses straddling one clock edge, from both settled levels
        base_rise = rise_seen; base_chg = dout_changes;
        for (int w = 2; w <= 4; w++) begin
            @(posedge clk);
            #9 din = 1'b1;
            #(w) din = 1'b0;
            repeat (4) tick();
            g_exp += g_inc;
        end
        chk("t3_low_no_rise", rise_seen - base_rise, 0);
        chk("t3_low_dout", dout, 0);
        din = 1'b1;
        repeat (7) tick();
        chk("t3_settled_high", dout, 1);
        chk("t3_edge_cnt", edge_cnt, 2);
        base_chg = dout_changes;
        for (int w = 2; w <= 4; w++) begin
            @(posedge clk);
            #9 din = 1'b0;
            #(w) din = 1'b1;
            repeat (4) tick();
            g_exp += g_inc;
        end
        chk("t3_high_no_change", dout_changes - base_chg, 0);
        chk("t3_glitch_cnt", glitch_cnt, g_exp);
        din = 1'b0;
        repeat (7) tick();
        chk("t3_settled_low", dout, 0);

        // 4: clear, wrap after 256 accepted rises, clear coincident with rise
        clr = 1'b1;
        tick();
        clr = 1'b0;
        g_exp = 0;
        chk("t4_clr_edge_cnt", edge_cnt, 0);
        chk("t4_clr_glitch_cnt", glitch_cnt, 0);
        chk("t4_clr_dout", dout, 0);
        base_rise = rise_seen;
        repeat (255) qual_rise();
        chk("t4_edge_cnt_255", edge_cnt, 255);
        qual_rise();
        chk("t4_edge_cnt_wrap", edge_cnt, 0);
        chk("t4_rise_count", rise_seen - base_rise, 256);
        qual_rise();
        chk("t4_edge_cnt_after_wrap", edge_cnt, 1);
        din = 1'b1;
        repeat (5) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t4_clr_rise", rise, 1);
        chk("t4_clr_rise_edge_cnt", edge_cnt, 1);
        din = 1'b0;
        repeat (7) tick();
        chk("t4_back_low", dout, 0);

        // 5: reset in the middle of RISE_CHK with din held high
        din = 1'b1;
        repeat (3) tick();
        reset_n = 1'b0;
        #2;
        chk("t5_reset_outputs", {dout, rise, fall}, 0);
        chk("t5_reset_edge_cnt", edge_cnt, 0);
        chk("t5_reset_glitch_cnt", glitch_cnt, 0);
        repeat (2) tick();
        reset_n = 1'b1;
        g_exp = 0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("t5_early_dout_%0d", i), dout, 0);
        end
        tick();
        chk("t5_requal_dout", dout, 1);
        chk("t5_requal_rise", rise, 1);
        chk("t5_requal_edge_cnt", edge_cnt, 1);
        chk("t5_glitch_cnt", glitch_cnt, g_exp);

        // 6: STABLE_CYCLES=1 instance follows single-sample changes after two edges
        din1 = 1'b1;
        tick();
        chk("t6_dout1_e1", dout1, 0);
        tick();
        chk("t6_dout1_e2", dout1, 0);
        tick();
        chk("t6_dout1_rise", {dout1, rise1}, 3);
        tick();
        chk("t6_rise1_one_cycle", rise1, 0);
        din1 = 1'b0;
        tick();
        din1 = 1'b1;
        tick();
        tick();
        chk("t6_pulse_fall", {dout1, fall1}, 1);
        tick();
        chk("t6_pulse_rise", {dout1, rise1}, 3);
        chk("t6_edge_cnt1", edge_cnt1, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
